rvv_vload_seq: RTL and testbench

- Unit-stride vector load sequencer that sits directly upstream of rvv_vregs and drives its write port (waddr/wstrb/wdata).
- Accepts one load command: destination vd, word-aligned base address, byte count.
- Issues sequential 32-bit memory reads over a valid/ready memory port.
- Writes each returned word into the correct byte lanes of vd, vd+1, ... (register group), then pulses done.

---
 rtl/rvv_pkg.sv | 27 ++
 rtl/rvv_lane_strb.sv | 32 +++
 rtl/rvv_vload_seq.sv | 135 +++++++++++++
 tb/tb_rvv_vload_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_pkg.sv
// Shared definitions for the vector load/store sequencing path: default
// register width, command field widths, sequencer state encoding and the
// per-beat byte-count helper.
package rvv_pkg;

    localparam int VLEN_DEFAULT = 128;
    localparam int VD_W         = 5;
    localparam int NBYTES_W     = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Register width in bytes for a given register width in bits.
    function automatic int vlenb_of(input int vlen);
        return vlen >> 3;
    endfunction

    // Bytes moved by one 32-bit beat: min(remaining, 4).
    function automatic logic [2:0] beat_bytes(input logic [NBYTES_W-1:0] remaining);
        return (remaining >= NBYTES_W'(4)) ? 3'd4 : remaining[2:0];
    endfunction

endpackage

// File: rtl/rvv_lane_strb.sv
// Places one 32-bit memory word into its byte lanes of a vector register
// write and builds the matching byte strobe, trimmed to the bytes still owed.
// Purely combinational so both the load and store paths can share it.
module rvv_lane_strb
    import rvv_pkg::*;
#(
    parameter int VLEN = VLEN_DEFAULT
) (
    input  logic [NBYTES_W-1:0]                 byte_idx,
    input  logic [NBYTES_W-1:0]                 remaining,
    input  logic [31:0]                         word,
    output logic [$clog2(vlenb_of(VLEN))-1:0]   lane,
    output logic [vlenb_of(VLEN)-1:0]           wstrb,
    output logic [VLEN-1:0]                     wdata
);

    localparam int VLENB  = vlenb_of(VLEN);
    localparam int LANE_W = $clog2(VLENB);

    logic [2:0] nbytes;
    logic [3:0] mask4;

    // Lane offset, strobe and shifted data for the current beat.
    always_comb begin
        lane   = LANE_W'(byte_idx % NBYTES_W'(VLENB));
        nbytes = beat_bytes(remaining);
        mask4  = (nbytes == 3'd4) ? 4'hf : ((4'h1 << nbytes) - 4'h1);
        wstrb  = VLENB'(mask4) << lane;
        wdata  = VLEN'(word) << {lane, 3'b000};
    end

endmodule

// File: rtl/rvv_vload_seq.sv
// Unit-stride vector load sequencer. Takes one command (vd, base address,
// byte count), reads memory one aligned word at a time and writes each word
// into the right byte lanes of vd, vd+1, ... through the register file's
// write port, then pulses done (with err for a misaligned base).
module rvv_vload_seq
    import rvv_pkg::*;
#(
    parameter int VLEN = VLEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [VD_W-1:0]         cmd_vd,
    input  logic [31:0]             cmd_addr,
    input  logic [NBYTES_W-1:0]     cmd_nbytes,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [31:0]             mem_addr,
    input  logic [31:0]             mem_rdata,
    output logic [VD_W-1:0]         vreg_waddr,
    output logic [(VLEN>>3)-1:0]    vreg_wstrb,
    output logic [VLEN-1:0]         vreg_wdata,
    output logic                    done,
    output logic                    err
);

    localparam int VLENB  = vlenb_of(VLEN);
    localparam int LANE_W = $clog2(VLENB);

    seq_state_t            state;
    logic [VD_W-1:0]       vd_q;
    logic [31:0]           cur_addr;
    logic [NBYTES_W-1:0]   remaining;
    logic [NBYTES_W-1:0]   byte_idx;

    logic [LANE_W-1:0]     lane_unused;
    logic [VLENB-1:0]      beat_strb;
    logic [VLEN-1:0]       beat_data;
    logic [VD_W-1:0]       beat_reg;
    logic [NBYTES_W-1:0]   beat_cnt;

    assign cmd_ready = (state == IDLE);

    // Register within the group that the current byte index falls into;
    // the 5-bit add wraps a group running past v31 back to v0.
    assign beat_reg = vd_q + VD_W'(byte_idx >> LANE_W);
    assign beat_cnt = NBYTES_W'(beat_bytes(remaining));

    // The lane offset itself is not needed here; strobe and data are already positioned.
    rvv_lane_strb #(
        .VLEN(VLEN)
    ) u_lane_strb (
        .byte_idx (byte_idx),
        .remaining(remaining),
        .word     (mem_rdata),
        .lane     (lane_unused),
        .wstrb    (beat_strb),
        .wdata    (beat_data)
    );

    // Sequencer: command accept, memory request/response, register write-back, completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            vd_q       <= '0;
            cur_addr   <= '0;
            remaining  <= '0;
            byte_idx   <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            vreg_waddr <= '0;
            vreg_wstrb <= '0;
            vreg_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done       <= 1'b0;
            vreg_wstrb <= '0;
            vreg_wdata <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        vd_q      <= cmd_vd;
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_nbytes;
                        byte_idx  <= '0;
                        if (cmd_addr[1:0] != 2'b00) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (cmd_nbytes == '0) begin
                            err   <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err       <= 1'b0;
                            mem_valid <= 1'b1;
                            mem_addr  <= cmd_addr;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid  <= 1'b0;
                        vreg_waddr <= beat_reg;
                        vreg_wstrb <= beat_strb;
                        vreg_wdata <= beat_data;
                        state      <= WB;
                    end
                end
                WB: begin
                    byte_idx  <= byte_idx + NBYTES_W'(4);
                    cur_addr  <= cur_addr + 32'd4;
                    remaining <= remaining - beat_cnt;
                    if (remaining == beat_cnt) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem_valid <= 1'b1;
                        mem_addr  <= cur_addr + 32'd4;
                        state     <= REQ;
                    end
                end
                DONE: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_vload_seq.sv
// Testbench for rvv_vload_seq: a reference model expands each command into
// the expected memory addresses, register writes and completion, and a
// monitor compares DUT activity against those queues as it appears.
module tb_rvv_vload_seq;

    localparam int VLEN  = 128;
    localparam int VLENB = VLEN / 8;

    typedef struct {
        logic [4:0]       waddr;
        logic [VLENB-1:0] strb;
        logic [VLEN-1:0]  data;
    } wr_t;

    typedef struct {
        logic err;
        int   nwr;
    } done_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [4:0]        cmd_vd = '0;
    logic [31:0]       cmd_addr = '0;
    logic [16:0]       cmd_nbytes = '0;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic [4:0]        vreg_waddr;
    logic [VLENB-1:0]  vreg_wstrb;
    logic [VLEN-1:0]   vreg_wdata;
    logic              done;
    logic              err;

    logic [31:0] exp_addr[$];
    wr_t         exp_wr[$];
    done_t       exp_done[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;
    int last_wr_cyc = 0;
    int dones_seen = 0;
    bit first_req_pending = 1'b0;
    bit hold_ready = 1'b0;

    rvv_vload_seq #(.VLEN(VLEN)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_vd    (cmd_vd),
        .cmd_addr  (cmd_addr),
        .cmd_nbytes(cmd_nbytes),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .vreg_waddr(vreg_waddr),
        .vreg_wstrb(vreg_wstrb),
        .vreg_wdata(vreg_wdata),
        .done      (done),
        .err       (err)
    );

    // 10 ns clock and a free-running cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check_output(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder with random wait states; data outside a handshake is junk
    always @(posedge clk) begin
        #1;
        if (mem_valid && !hold_ready) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = mem_ready ? mem_word(mem_addr) : $urandom;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
    end

    // Monitor: compare every request, write and completion against the model queues
    always @(negedge clk) begin
        if (resetn) begin
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                first_req_pending = 1'b1;
            end
            if (mem_valid) begin
                if (first_req_pending) begin
                    check_output("req_latency", VLEN'(cyc), VLEN'(acc_cyc + 1));
                    first_req_pending = 1'b0;
                end
                check_output("req_expected", VLEN'(exp_addr.size() != 0), VLEN'(1));
                if (exp_addr.size() != 0) begin
                    check_output("mem_addr", VLEN'(mem_addr), VLEN'(exp_addr[0]));
                    if (mem_ready) begin
                        void'(exp_addr.pop_front());
                        hs_cyc = cyc;
                    end
                end
            end
            if (vreg_wstrb != '0) begin
                check_output("write_expected", VLEN'(exp_wr.size() != 0), VLEN'(1));
                if (exp_wr.size() != 0) begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check_output("vreg_waddr", VLEN'(vreg_waddr), VLEN'(w.waddr));
                    check_output("vreg_wstrb", VLEN'(vreg_wstrb), VLEN'(w.strb));
                    check_output("vreg_wdata", vreg_wdata, w.data);
                    check_output("wb_latency", VLEN'(cyc), VLEN'(hs_cyc + 1));
                    last_wr_cyc = cyc;
                end
            end
            if (done) begin
                check_output("done_expected", VLEN'(exp_done.size() != 0), VLEN'(1));
                if (exp_done.size() != 0) begin
                    done_t d;
                    d = exp_done.pop_front();
                    check_output("err", VLEN'(err), VLEN'(d.err));
                    if (d.nwr > 0)
                        check_output("done_latency", VLEN'(cyc), VLEN'(last_wr_cyc + 1));
                    else
                        check_output("done_latency", VLEN'(cyc), VLEN'(acc_cyc + 1));
                end
                dones_seen++;
            end
        end
    end

    // Issue one command and load the model's expectations for it
    task automatic apply_stimulus(input logic [4:0] vd, input logic [31:0] addr, input int nbytes, input bit wait_done);
        int t;
        int rem;
        int b;
        int n;
        int lane;
        int nwr;
        int start;
        wr_t w;
        done_t d;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("cmd_ready", VLEN'(cmd_ready), VLEN'(1));
        nwr = 0;
        if (addr[1:0] != 2'b00) begin
            d.err = 1'b1;
        end else begin
            d.err = 1'b0;
            rem = nbytes;
            b = 0;
            while (rem > 0) begin
                n = (rem < 4) ? rem : 4;
                lane = b % VLENB;
                w.waddr = 5'((int'(vd) + b / VLENB) % 32);
                w.strb = '0;
                w.data = '0;
                for (int k = 0; k < n; k++) w.strb[lane + k] = 1'b1;
                w.data[lane*8 +: 32] = mem_word(addr + 32'(b));
                exp_addr.push_back(addr + 32'(b));
                exp_wr.push_back(w);
                nwr++;
                rem -= n;
                b += 4;
            end
        end
        d.nwr = nwr;
        exp_done.push_back(d);
        start = dones_seen;
        cmd_vd = vd;
        cmd_addr = addr;
        cmd_nbytes = 17'(nbytes);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_vd = 5'($urandom);
        cmd_addr = $urandom;
        cmd_nbytes = 17'($urandom);
        if (wait_done) begin
            t = 0;
            while (dones_seen == start && t < 3000) begin
                @(posedge clk); #1;
                t++;
            end
            check_output("done_seen", VLEN'(dones_seen != start), VLEN'(1));
        end
    endtask

    // Wait (bounded) for a memory request to appear
    task automatic wait_mem_valid();
        int t;
        t = 0;
        while (!mem_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("mem_valid_seen", VLEN'(mem_valid), VLEN'(1));
    endtask

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        logic [31:0] a;
        logic [31:0] stall_addr;
        #22;
        check_output("rst_mem_valid", VLEN'(mem_valid), VLEN'(0));
        check_output("rst_mem_addr", VLEN'(mem_addr), VLEN'(0));
        check_output("rst_wstrb", VLEN'(vreg_wstrb), VLEN'(0));
        check_output("rst_wdata", vreg_wdata, VLEN'(0));
        check_output("rst_waddr", VLEN'(vreg_waddr), VLEN'(0));
        check_output("rst_done", VLEN'(done), VLEN'(0));
        check_output("rst_err", VLEN'(err), VLEN'(0));
        check_output("rst_cmd_ready", VLEN'(cmd_ready), VLEN'(1));
        @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed cases: single word, partial tail, multi-word, group wrap, max size
        apply_stimulus(5'd4,  32'h0000_0100, 4,   1'b1);
        apply_stimulus(5'd2,  32'h0000_0200, 6,   1'b1);
        apply_stimulus(5'd7,  32'h0000_0300, 8,   1'b1);
        apply_stimulus(5'd31, 32'h0000_0400, 32,  1'b1);
        apply_stimulus(5'd30, 32'h0000_0500, 37,  1'b1);
        apply_stimulus(5'd28, 32'h0000_0700, 128, 1'b1);
        apply_stimulus(5'd5,  32'h0000_0102, 16,  1'b1);
        apply_stimulus(5'd6,  32'h0000_0600, 0,   1'b1);
        apply_stimulus(5'd1,  32'h0000_0803, 0,   1'b1);

        // Stalled memory: request must hold still while mem_ready stays low
        hold_ready = 1'b1;
        apply_stimulus(5'd12, 32'h0000_0A00, 10, 1'b0);
        wait_mem_valid();
        stall_addr = 32'h0000_0A00;
        repeat (5) begin
            @(posedge clk); #1;
            check_output("stall_mem_valid", VLEN'(mem_valid), VLEN'(1));
            check_output("stall_mem_addr", VLEN'(mem_addr), VLEN'(stall_addr));
            check_output("stall_wstrb", VLEN'(vreg_wstrb), VLEN'(0));
        end
        hold_ready = 1'b0;
        begin
            int t;
            t = 0;
            while (exp_done.size() != 0 && t < 500) begin
                @(posedge clk); #1;
                t++;
            end
            check_output("stall_complete", VLEN'(exp_done.size()), VLEN'(0));
        end

        // Reset dropped while a request is outstanding
        hold_ready = 1'b1;
        apply_stimulus(5'd20, 32'h0000_0C00, 64, 1'b0);
        wait_mem_valid();
        #2;
        resetn = 1'b0;
        #1;
        check_output("arst_mem_valid", VLEN'(mem_valid), VLEN'(0));
        check_output("arst_wstrb", VLEN'(vreg_wstrb), VLEN'(0));
        check_output("arst_done", VLEN'(done), VLEN'(0));
        exp_addr.delete();
        exp_wr.delete();
        exp_done.delete();
        first_req_pending = 1'b0;
        hold_ready = 1'b0;
        @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        check_output("post_rst_cmd_ready", VLEN'(cmd_ready), VLEN'(1));
        check_output("post_rst_mem_valid", VLEN'(mem_valid), VLEN'(0));
        apply_stimulus(5'd3, 32'h0000_0E00, 12, 1'b1);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            apply_stimulus(5'($urandom), a, $urandom_range(0, 8 * VLENB), 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        check_output("queues_empty", VLEN'(exp_addr.size() + exp_wr.size() + exp_done.size()), VLEN'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
